// File: rtl/wb_apb_bridge.sv
// wb_apb_bridge: Wishbone classic responder that re-issues each access as one APB4 transfer.
// Latency: stb sampled at edge 0 -> SETUP, ACCESS, ack/err visible after edge 2 (+1 per pready=0 cycle).
// Backpressure: one outstanding transfer, Wishbone held until APB completes; WBAPB_TIMEOUT_EN bounds ACCESS.
module wb_apb_bridge #(
  parameter int                ADDR_W         = 32,
  parameter int                DATA_W         = 32,
  parameter int                TIMEOUT_CYCLES = 255,
  parameter logic [DATA_W-1:0] TO_RDATA       = 32'hDEAD_BEEF
) (
  input  logic                clk,
  input  logic                RESET_N,
  input  logic                wb_cyc,
  input  logic                wb_stb,
  input  logic                wb_we,
  input  logic [ADDR_W-1:0]   wb_adr,
  input  logic [DATA_W-1:0]   wb_wdata,
  input  logic [DATA_W/8-1:0] wb_sel,
  output logic [DATA_W-1:0]   wb_rdata,
  output logic                wb_ack,
  output logic                wb_err,
  output logic [ADDR_W-1:0]   paddr,
  output logic                psel,
  output logic                penable,
  output logic                pwrite,
  output logic [DATA_W-1:0]   pwdata,
  output logic [DATA_W/8-1:0] pstrb,
  input  logic [DATA_W-1:0]   prdata,
  input  logic                pready,
  input  logic                pslverr
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t state_q, state_d;
  logic   abort_q, abort_d;   // master dropped wb_cyc while the APB transfer was in flight
  logic   err_q;              // termination kind for the RESP cycle
  logic   req_take;           // IDLE accepts a new request this cycle
  logic   done;               // ACCESS completes with pready this cycle

`ifdef WBAPB_TIMEOUT_EN
  // Counter is at least 8 bits and at most 16 bits wide.
  localparam int TO_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int TO_W   = (TO_RAW < 8) ? 8 : ((TO_RAW > 16) ? 16 : TO_RAW);
  // Counter holds k during the k-th ACCESS cycle (from 0); firing when the next
  // increment would reach TIMEOUT_CYCLES gives exactly TIMEOUT_CYCLES ACCESS cycles.
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] to_cnt;
  logic            to_hit;
`else
  // Timeout parameters only matter when the timeout feature is built in.
  logic unused_params;
  assign unused_params = ^{TO_RDATA, TIMEOUT_CYCLES};
`endif

  // Next-state logic: IDLE -> SETUP -> ACCESS (wait on pready) -> RESP -> IDLE.
  always_comb begin
    state_d  = state_q;
    abort_d  = abort_q;
    req_take = 1'b0;
    done     = 1'b0;
`ifdef WBAPB_TIMEOUT_EN
    to_hit   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (wb_cyc && wb_stb) begin
          req_take = 1'b1;
          abort_d  = 1'b0;
          state_d  = S_SETUP;
        end
      end
      S_SETUP: begin
        if (!wb_cyc) abort_d = 1'b1;
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        if (!wb_cyc) abort_d = 1'b1;
        if (pready) begin
          done    = 1'b1;
          state_d = S_RESP;
        end
`ifdef WBAPB_TIMEOUT_EN
        else if (to_cnt == TO_LIMIT) begin
          to_hit  = 1'b1;
          state_d = S_RESP;
        end
`endif
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, abort flag and termination kind registers.
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= S_IDLE;
      abort_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      abort_q <= abort_d;
      if (done) err_q <= pslverr;
`ifdef WBAPB_TIMEOUT_EN
      if (to_hit) err_q <= 1'b1;
`endif
    end
  end

  // Request latch: APB address/data/strobes hold their values until the next request.
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      paddr  <= '0;
      pwrite <= 1'b0;
      pwdata <= '0;
      pstrb  <= '0;
    end else if (req_take) begin
      paddr  <= wb_adr;
      pwrite <= wb_we;
      pwdata <= wb_wdata;
      pstrb  <= wb_we ? wb_sel : '0;
    end
  end

  // Read data register: captured only on a read that terminates towards the master.
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      wb_rdata <= '0;
    end else if (done && !pwrite && !abort_d) begin
      wb_rdata <= prdata;
    end
`ifdef WBAPB_TIMEOUT_EN
    else if (to_hit && !pwrite && !abort_d) begin
      wb_rdata <= TO_RDATA;
    end
`endif
  end

`ifdef WBAPB_TIMEOUT_EN
  // Wait-state counter: zero outside ACCESS, counts pready=0 cycles inside it.
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      to_cnt <= '0;
    end else if (state_q != S_ACCESS) begin
      to_cnt <= '0;
    end else if (!pready) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end
`endif

  // Phase decode straight from the state register so reset clears it without a clock.
  assign psel    = (state_q == S_SETUP) || (state_q == S_ACCESS);
  assign penable = (state_q == S_ACCESS);
  assign wb_ack  = (state_q == S_RESP) && !abort_q && !err_q;
  assign wb_err  = (state_q == S_RESP) && !abort_q && err_q;

endmodule

// File: doc/wb_apb_bridge.md
Name: wb_apb_bridge

Overview:
- Wishbone classic responder that terminates one master port of the core's Wishbone interconnect and re-issues each access as an APB4 transfer to the peripheral segment.
- Turns Wishbone cyc/stb/ack cycles into APB setup/access phases, returns read data, and maps PSLVERR to a Wishbone error termination.
- One outstanding transfer; no buffering beyond the latched request.

Parameters:
- ADDR_W, 32, address width on both sides.
- DATA_W, 32, data width on both sides (multiple of 8).
- TIMEOUT_CYCLES, 255, maximum ACCESS-phase cycles before forced termination (used only with WBAPB_TIMEOUT_EN).
- TO_RDATA, 32'hDEAD_BEEF, read data returned on timeout.

Ports:
- clk  in  1  system clock.
- RESET_N  in  1  asynchronous active-low reset.
- wb_cyc  in  1  Wishbone cycle valid.
- wb_stb  in  1  Wishbone strobe.
- wb_we  in  1  1 = write.
- wb_adr  in  ADDR_W  byte address.
- wb_wdata  in  DATA_W  write data.
- wb_sel  in  DATA_W/8  byte selects.
- wb_rdata  out  DATA_W  read data, valid when wb_ack=1.
- wb_ack  out  1  normal termination.
- wb_err  out  1  error termination.
- paddr  out  ADDR_W  APB address.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- pwdata  out  DATA_W  APB write data.
- pstrb  out  DATA_W/8  APB strobes; forced to 0 on reads.
- prdata  in  DATA_W  APB read data.
- pready  in  1  APB ready.
- pslverr  in  1  APB error.

Behaviour:
- Reset: all outputs 0 and FSM in IDLE, applied immediately on RESET_N low.
- States:
  - IDLE -> SETUP when wb_cyc & wb_stb. Latch adr/wdata/sel/we.
  - SETUP: psel=1, penable=0. Always -> ACCESS.
  - ACCESS: psel=1, penable=1. Stays while pready=0. On pready=1 capture prdata and pslverr -> RESP.
  - RESP: psel=penable=0. Exactly one of wb_ack/wb_err high for one cycle. -> IDLE.
- Latency:
  - Zero-wait APB slave: stb seen at edge 0, SETUP at 1, ACCESS at 2, ack/err at 3.
  - Each pready=0 cycle adds one cycle.
- APB outputs (paddr, pwrite, pwdata, pstrb) are stable from SETUP through the last ACCESS cycle.
- Outside the SETUP/ACCESS window these outputs hold their last values; only psel and penable return to 0.
- wb_rdata is the registered prdata:
  - Updated only on a completed read.
  - Write completions leave it unchanged.
  - Error completions still capture prdata.
- pslverr=1 with pready=1 -> wb_err=1 and wb_ack=0, for both reads and writes.
- wb_ack and wb_err are never high together and never high for two consecutive cycles.
- Back-to-back: IDLE always lasts at least one cycle after RESP. A new request is sampled in IDLE only.
- Master abort: if wb_cyc drops during SETUP or ACCESS, the APB transfer still completes. Termination is then suppressed: no ack/err pulse, and wb_rdata is not updated.
- wb_stb with wb_cyc=0 is ignored.
- Reset mid-transfer: psel/penable drop asynchronously, FSM returns to IDLE, and the transfer is lost.

Optional Feature:
- Macro: WBAPB_TIMEOUT_EN.
- Defined:
  - An 8..16-bit counter clears on entry to ACCESS and increments each ACCESS cycle with pready=0.
  - When the count reaches TIMEOUT_CYCLES with pready still 0, go to RESP with wb_err=1.
  - On a read timeout, wb_rdata=TO_RDATA. psel/penable deassert.
  - pready=1 in the same cycle as the limit is a normal completion.
- Not defined:
  - No counter logic is present.
  - ACCESS waits indefinitely for pready; TIMEOUT_CYCLES and TO_RDATA are unused.

Test Plan:
- Write, zero-wait: adr=0x4000_0010, wdata=0x1234_5678, sel=4'hF, pready held 1 -> one SETUP cycle then one ACCESS cycle with pwrite=1 and pstrb=4'hF; wb_ack pulses 3 cycles after stb; wb_err=0.
- Read with 2 wait states: adr=0x4000_0020, pready low for 2 ACCESS cycles, prdata=0xCAFE_F00D -> ack 5 cycles after stb; wb_rdata=0xCAFE_F00D; pstrb=0.
- Error: write with pslverr=1 on the pready cycle -> wb_err=1 for one cycle; wb_ack stays 0; the next read completes normally with ack.
- Abort: drop wb_cyc during ACCESS while pready=0, then raise pready -> APB transfer completes; no ack or err; FSM back in IDLE.
- Reset mid-ACCESS: RESET_N low asynchronously -> psel=penable=wb_ack=0 without waiting for a clock edge; a transfer after release runs normally.
- Timeout (WBAPB_TIMEOUT_EN, TIMEOUT_CYCLES=4): read with pready held 0 -> wb_err after 4 ACCESS cycles; wb_rdata=0xDEAD_BEEF; psel drops.
